// File: rtl/sipo_deser.sv
`default_nettype none
// sipo_deser: parametrised serial-to-parallel deserialiser with valid/ready holding register and sticky overrun.
// Build option SIPO_PARITY_EN: each frame carries a trailing even-parity bit, reported on p_perr.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             sync,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             p_perr
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int            CW   = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    slot;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             hold_free;
  logic             load;

  // sync makes the current cycle look like the start of a fresh frame.
  always_comb begin
    slot    = sync ? '0 : cnt;
    sr_base = sync ? '0 : sr;
    word    = sr_base;
    for (int i = 0; i < WIDTH; i++) begin
      if (slot == CW'((MSB_FIRST != 0) ? (WIDTH - 1 - i) : i)) begin
        word[i] = s_data;
      end
    end
    complete  = s_valid && (slot == LAST);
    hold_free = !p_valid || p_ready;
    load      = complete && hold_free;

    cnt_next = slot;
    sr_next  = sr_base;
    if (s_valid) begin
      sr_next  = word;
      cnt_next = complete ? '0 : (slot + CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      sr      <= '0;
      p_data  <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= cnt_next;
      sr  <= sr_next;
      if (load) begin
        p_data  <= word;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
      // A fresh overrun takes priority over a clear in the same cycle.
      if (complete && !hold_free) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  // On completion the incoming bit is the parity bit; sr_base holds the full data word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_perr <= 1'b0;
    end else if (load) begin
      p_perr <= (^sr_base) ^ s_data;
    end
  end
`else
  assign p_perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// tb_sipo_deser: directed self-checking bench for sipo_deser (WIDTH=8 MSB/LSB first, WIDTH=1).
module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
  localparam int FRAME_N = 9;
`else
  localparam int FRAME_N = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_data;
  logic       sync;
  logic       p_ready;
  logic       ovr_clr;

  logic [7:0] a_data;
  logic       a_valid, a_overrun, a_perr;
  logic [7:0] b_data;
  logic       b_valid, b_overrun, b_perr;
  logic [0:0] c_data;
  logic       c_valid, c_overrun, c_perr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .sync(sync),
    .p_data(a_data), .p_valid(a_valid), .p_ready(p_ready), .overrun(a_overrun),
    .ovr_clr(ovr_clr), .p_perr(a_perr)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .sync(sync),
    .p_data(b_data), .p_valid(b_valid), .p_ready(p_ready), .overrun(b_overrun),
    .ovr_clr(ovr_clr), .p_perr(b_perr)
  );

  sipo_deser #(.WIDTH(1), .MSB_FIRST(1)) dut_c (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .sync(sync),
    .p_data(c_data), .p_valid(c_valid), .p_ready(1'b1), .overrun(c_overrun),
    .ovr_clr(ovr_clr), .p_perr(c_perr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends bits[n-1] first, one qualified bit per cycle.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      s_valid = 1'b1;
      s_data  = bits[i];
      tick();
    end
    s_valid = 1'b0;
    s_data  = 1'b0;
  endtask

  function automatic logic [31:0] frame_bits(input logic [7:0] w);
`ifdef SIPO_PARITY_EN
    return {23'd0, w, ^w};
`else
    return {24'd0, w};
`endif
  endfunction

  task automatic send_word(input logic [7:0] w);
    send_bits(frame_bits(w), FRAME_N);
  endtask

  initial begin
    logic [31:0] bits;
    logic [31:0] stream;
    int          n;
    logic [7:0]  seen[$];

    reset = 1'b0; s_valid = 1'b0; s_data = 1'b0; sync = 1'b0;
    p_ready = 1'b1; ovr_clr = 1'b0;
    tick();
    tick();
    check("rst_data", 32'(a_data), 32'h0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_overrun", 32'(a_overrun), 32'd0);
    check("rst_perr", 32'(a_perr), 32'd0);
    check("rst_b_perr", 32'(b_perr), 32'd0);
    reset = 1'b1;

    // 0xA5 on consecutive cycles; valid must not rise before the last bit.
    bits = frame_bits(8'hA5);
    for (int i = FRAME_N - 1; i >= 0; i--) begin
      s_valid = 1'b1;
      s_data  = bits[i];
      tick();
      if (i == 1) check("a5_early_valid", 32'(a_valid), 32'd0);
    end
    s_valid = 1'b0;
    check("a5_msb_data", 32'(a_data), 32'hA5);
    check("a5_msb_valid", 32'(a_valid), 32'd1);
    check("a5_lsb_data", 32'(b_data), 32'hA5);
    check("a5_lsb_valid", 32'(b_valid), 32'd1);
    tick();
    check("a5_valid_1cyc", 32'(a_valid), 32'd0);

    send_word(8'hC0);
    check("c0_msb_data", 32'(a_data), 32'hC0);
    check("c0_lsb_data", 32'(b_data), 32'h03);
    tick();

    // s_valid toggling every cycle across two words.
`ifdef SIPO_PARITY_EN
    stream = {14'd0, 8'h3C, 1'b0, 8'hF0, 1'b0};
    n = 18;
`else
    stream = {16'd0, 8'h3C, 8'hF0};
    n = 16;
`endif
    for (int i = n - 1; i >= 0; i--) begin
      s_valid = 1'b1;
      s_data  = stream[i];
      tick();
      if (a_valid) seen.push_back(a_data);
      s_valid = 1'b0;
      tick();
      if (a_valid) seen.push_back(a_data);
    end
    check("toggle_count", 32'(seen.size()), 32'd2);
    check("toggle_word0", 32'((seen.size() > 0) ? seen[0] : 8'hxx), 32'h3C);
    check("toggle_word1", 32'((seen.size() > 1) ? seen[1] : 8'hxx), 32'hF0);

    // Overrun with consumer stalled.
    p_ready = 1'b0;
    send_word(8'h11);
    check("ovr_first_valid", 32'(a_valid), 32'd1);
    check("ovr_first_data", 32'(a_data), 32'h11);
    send_word(8'h22);
    check("ovr_kept_data", 32'(a_data), 32'h11);
    check("ovr_set", 32'(a_overrun), 32'd1);
    check("ovr_set_b", 32'(b_overrun), 32'd1);
    check("ovr_valid_held", 32'(a_valid), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(a_overrun), 32'd0);
    ovr_clr = 1'b1;
    send_word(8'h33);
    ovr_clr = 1'b0;
    check("ovr_set_wins", 32'(a_overrun), 32'd1);
    check("ovr_set_wins_data", 32'(a_data), 32'h11);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared2", 32'(a_overrun), 32'd0);
    p_ready = 1'b1;
    tick();
    check("accept_valid", 32'(a_valid), 32'd0);
    check("accept_data", 32'(a_data), 32'h11);
    tick();
    check("accept_once", 32'(a_valid), 32'd0);

    // sync with a qualified bit restarts the frame at that bit.
    send_bits(32'b111, 3);
    s_valid = 1'b1; s_data = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0; s_valid = 1'b0;
`ifdef SIPO_PARITY_EN
    send_bits(32'b0000000_1, 8);
`else
    send_bits(32'b0000000, 7);
`endif
    check("sync_msb_data", 32'(a_data), 32'h80);
    check("sync_msb_valid", 32'(a_valid), 32'd1);
    check("sync_lsb_data", 32'(b_data), 32'h01);
    tick();

    // sync alone drops the partial word.
    send_bits(32'b101, 3);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    send_word(8'h5A);
    check("sync_idle_data", 32'(a_data), 32'h5A);

    // Reset mid-word.
    send_bits(32'b10110, 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_data", 32'(a_data), 32'h0);
    check("midrst_valid", 32'(a_valid), 32'd0);
    send_word(8'hFF);
    check("ff_data", 32'(a_data), 32'hFF);
    check("ff_valid", 32'(a_valid), 32'd1);
    check("ff_perr", 32'(a_perr), 32'd0);
`ifdef SIPO_PARITY_EN
    send_bits({23'd0, 8'hFF, 1'b1}, 9);
    check("ff_bad_par_perr", 32'(a_perr), 32'd1);
    check("ff_bad_par_data", 32'(a_data), 32'hFF);
    send_bits({23'd0, 8'hFF, 1'b0}, 9);
    check("ff_good_par_perr", 32'(a_perr), 32'd0);
`endif
    tick();

`ifndef SIPO_PARITY_EN
    // WIDTH=1: every qualified bit is a word, back to back.
    s_valid = 1'b1; s_data = 1'b1;
    tick();
    check("w1_data1", 32'(c_data), 32'd1);
    check("w1_valid1", 32'(c_valid), 32'd1);
    s_data = 1'b0;
    tick();
    check("w1_data0", 32'(c_data), 32'd0);
    check("w1_valid_b2b", 32'(c_valid), 32'd1);
    s_valid = 1'b0;
    tick();
    check("w1_valid_clr", 32'(c_valid), 32'd0);
    check("w1_perr", 32'(c_perr), 32'd0);
`endif
    check("w1_no_overrun", 32'(c_overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
